// File: rtl/weight_pkg.sv
// Shared weight-path constants and the loader state encoding.
// Used by both the weight RAM loader and the weight RAM itself.
package weight_pkg;

    localparam int DEF_NROW     = 16;
    localparam int DEF_NCOL     = 16;
    localparam int DEF_BITWIDTH = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/weight_col_packer.sv
// Column buffer: NROW slots of BITWIDTH bits, one slot written per accepted word.
// Slot i sits at [i*BITWIDTH +: BITWIDTH], matching the read path's rowOutput layout.
module weight_col_packer #(
    parameter int NROW     = 16,
    parameter int BITWIDTH = 18,
    parameter int RW       = (NROW > 1) ? $clog2(NROW) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [RW-1:0]            row_i,
    input  logic [BITWIDTH-1:0]      data_i,
    output logic [NROW*BITWIDTH-1:0] col_o
);

    for (genvar i = 0; i < NROW; i++) begin : g_slot
        logic [BITWIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slot_q <= '0;
            end else if (we_i && (row_i == RW'(i))) begin
                slot_q <= data_i;
            end
        end

        assign col_o[i*BITWIDTH +: BITWIDTH] = slot_q;
    end

endmodule

// File: rtl/weight_ram_loader.sv
// Packs a valid/ready weight stream into column words and writes one RAM column per NROW words.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a running sum of accepted weights on `checksum`.
module weight_ram_loader
    import weight_pkg::*;
#(
    parameter int NROW          = DEF_NROW,
    parameter int NCOL          = DEF_NCOL,
    parameter int BITWIDTH      = DEF_BITWIDTH,
    parameter int COL_WIDTH     = BITWIDTH * NROW,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [BITWIDTH-1:0]      in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDR_BITWIDTH-1:0] wr_addr,
    output logic [COL_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [BITWIDTH+$clog2(NROW*NCOL)-1:0] checksum
`endif
);

    localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;

    loader_state_t            state_q, state_d;
    logic [RW-1:0]            row_q, row_d;
    logic [ADDR_BITWIDTH-1:0] col_q, col_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic                     ready_q, wen_q, busy_q, done_q;
    logic                     accept, launch;

    assign accept = in_valid && ready_q;
    assign launch = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (row_q == RW'(NROW - 1)) begin
                        row_d   = '0;
                        state_d = WRITE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (col_q == ADDR_BITWIDTH'(NCOL - 1)) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
        // address is latched on WRITE entry so it is stable for the whole strobe
        if (state_d == WRITE) begin
            addr_d = col_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            ready_q <= (state_d == COLLECT);
            wen_q   <= (state_d == WRITE);
            busy_q  <= (state_d == COLLECT) || (state_d == WRITE);
            done_q  <= (state_d == DONE);
        end
    end

    weight_col_packer #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH),
        .RW       (RW)
    ) u_packer (
        .clk    (clk),
        .reset  (reset),
        .we_i   (accept),
        .row_i  (row_q),
        .data_i (in_data),
        .col_o  (wr_data)
    );

    assign in_ready = ready_q;
    assign wr_en    = wen_q;
    assign wr_addr  = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int CSW = BITWIDTH + $clog2(NROW * NCOL);

    logic [CSW-1:0] cs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q <= '0;
        end else if (launch) begin
            cs_q <= '0;
        end else if (accept) begin
            cs_q <= cs_q + CSW'(in_data);
        end
    end

    assign checksum = cs_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_weight_ram_loader.sv
// Randomized bench for weight_ram_loader with a transaction-level reference model.
// Builds with or without WEIGHT_LOADER_CHECKSUM_EN.
module tb_weight_ram_loader;

    localparam int NROW = 4;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int COLW = BW * NROW;
    localparam int AW   = 2;
    localparam int CSW  = BW + $clog2(NROW * NCOL);

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic [BW-1:0]   in_data;
    logic            in_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [COLW-1:0] wr_data;
    logic            busy;
    logic            done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [CSW-1:0]  checksum;
`endif

    weight_ram_loader #(
        .NROW          (NROW),
        .NCOL          (NCOL),
        .BITWIDTH      (BW),
        .COL_WIDTH     (COLW),
        .ADDR_BITWIDTH (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a load is NCOL groups of NROW accepted words;
    // each completed group is followed by exactly one write cycle.
    bit              m_loading;
    bit              m_pend;
    bit              m_done;
    int              m_writes;
    int              m_sum;
    logic [BW-1:0]   words[$];
    logic [COLW-1:0] expc;
    logic [COLW-1:0] cap[NCOL];

    always @(negedge clk) begin
        if (!reset) begin
            m_loading = 0;
            m_pend    = 0;
            m_done    = 0;
            m_writes  = 0;
            m_sum     = 0;
            words.delete();
        end else begin
            chk("in_ready", in_ready, m_loading && !m_pend);
            chk("wr_en", wr_en, m_pend);
            chk("busy", busy, m_loading);
            chk("done", done, m_done);
            if (m_pend) begin
                chk("wr_addr", wr_addr, m_writes);
                expc = '0;
                for (int i = 0; i < NROW; i++)
                    expc[i*BW +: BW] = words[m_writes*NROW + i];
                chk("wr_data", wr_data, expc);
                cap[m_writes] = wr_data;
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            if (m_done) chk("checksum", checksum, m_sum);
`endif
            if (m_pend) begin
                m_pend = 0;
                m_writes++;
                if (m_writes == NCOL) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end else if (m_loading) begin
                if (in_valid) begin
                    words.push_back(in_data);
                    m_sum += int'(in_data);
                    if (words.size() % NROW == 0) m_pend = 1;
                end
            end else if (start) begin
                m_loading = 1;
                m_done    = 0;
                m_writes  = 0;
                m_sum     = 0;
                words.delete();
            end
        end
    end

    // mode 0: valid held; 1: valid toggles while ready; 2: random valid and start
    task automatic run_load(input int base, input int stride, input int mode,
                            output int cyc, output int idx);
        bit acc;
        bit ph;
        @(posedge clk); #1;
        start    = 1;
        in_valid = 0;
        @(posedge clk); #1;
        start = 0;
        chk("done_drop", done, 0);
        chk("busy_start", busy, 1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("cs_clear", checksum, 0);
`endif
        idx = 0;
        cyc = 0;
        ph  = 0;
        while (!done && cyc < 2000) begin
            case (mode)
                0: in_valid = 1;
                1: begin
                    if (in_ready) begin
                        in_valid = ph;
                        ph = !ph;
                    end else begin
                        in_valid = 0;
                        ph = 0;
                    end
                end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            in_data = BW'(base + idx * stride);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
        end
        start    = 0;
        in_valid = 0;
        chk("load_ends", done, 1);
    endtask

    logic [COLW-1:0] c;
    int cyc;
    int idx;

    initial begin
        reset    = 0;
        start    = 0;
        in_valid = 0;
        in_data  = '0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // abandon a load after 5 words
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start    = 0;
        in_valid = 1;
        in_data  = '0;
        repeat (5) begin
            @(posedge clk); #1;
            in_data = in_data + 1'b1;
        end
        chk("mid_busy", busy, 1);
        reset = 0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        in_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        in_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", in_ready, 0);
        chk("post_rst_wr_en", wr_en, 0);
        in_valid = 0;

        // full load, valid held
        run_load(0, 1, 0, cyc, idx);
        chk("lat_full", cyc, 20);
        chk("words_full", idx, 16);
        c = cap[0];
        for (int i = 0; i < NROW; i++) chk("col0_slot", c[i*BW +: BW], i);
        c = cap[3];
        for (int i = 0; i < NROW; i++) chk("col3_slot", c[i*BW +: BW], 12 + i);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("checksum_120", checksum, 120);
`endif

        // back-pressure
        run_load(0, 1, 1, cyc, idx);
        chk("lat_bp", cyc, 36);
        chk("words_bp", idx, 16);
        c = cap[2];
        for (int i = 0; i < NROW; i++) chk("bp_col2_slot", c[i*BW +: BW], 8 + i);

        // restart from DONE with new data
        run_load(100, 1, 0, cyc, idx);
        c = cap[0];
        chk("restart_slot0", c[BW-1:0], 100);
        c = cap[3];
        chk("restart_last", c[(NROW-1)*BW +: BW], 115);

        // random valid, stray start pulses, valid held in DONE
        for (int r = 0; r < 3; r++) begin
            run_load(int'($urandom_range(0, 200000)), int'($urandom_range(1, 5000)),
                     2, cyc, idx);
            chk("words_rnd", idx, 16);
            in_valid = 1;
            repeat (4) @(posedge clk);
            #1;
            chk("done_hold", done, 1);
            in_valid = 0;
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
